// File: rtl/rr_arbiter4_pkg.sv
// rtl/rr_arbiter4_pkg.sv - shared constants and state type for the round-robin arbiter
package rr_arbiter4_pkg;

    localparam int N_REQ            = 4;
    localparam int IDX_W            = 2;
    localparam int HOLD_W           = 8;
    localparam int DEFAULT_MAX_HOLD = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter4_if.sv
// rtl/rr_arbiter4_if.sv - request/grant bundle between requesting agents and the arbiter
interface rr_arbiter4_if;
    import rr_arbiter4_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             busy;
    logic             timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output busy,
        output timeout
    );

endinterface

// File: rtl/rr_arbiter4_grant_decode.sv
// rtl/rr_arbiter4_grant_decode.sv - 2-to-4 one-hot decoder with enable
module grant_decode
    import rr_arbiter4_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-requester round-robin arbiter with hold limit and idle gap
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arbiter4_if.slave bus
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    ptr, ptr_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic                timeout_r, timeout_nxt;

    logic [2*N_REQ-1:0]  req_dbl;
    logic [N_REQ-1:0]    req_rot;
    logic [IDX_W-1:0]    pick_off;
    logic [IDX_W-1:0]    pick;
    logic                any_req;
    logic                owner_req;
    logic                granted;

    // Rotate so the pointer position lands on bit 0, then take the lowest set bit.
    assign req_dbl = {bus.req, bus.req} >> ptr;
    assign req_rot = req_dbl[N_REQ-1:0];
    assign any_req = |bus.req;

    always_comb begin
        pick_off = '0;
        casez (req_rot)
            4'b???1: pick_off = 2'd0;
            4'b??10: pick_off = 2'd1;
            4'b?100: pick_off = 2'd2;
            4'b1000: pick_off = 2'd3;
            default: pick_off = 2'd0;
        endcase
    end

    assign pick      = ptr + pick_off;
    assign owner_req = bus.req[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            idx       <= '0;
            hold_cnt  <= '0;
            timeout_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            idx       <= idx_nxt;
            hold_cnt  <= hold_nxt;
            timeout_r <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        idx_nxt     = idx;
        hold_nxt    = hold_cnt;
        timeout_nxt = 1'b0;

        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = GRANT;
                    idx_nxt   = pick;
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (hold_cnt != HOLD_SAT) begin
                    hold_nxt = hold_cnt + 1'b1;
                end
                // done outranks the hold limit, so a collision never raises timeout.
                if (bus.done || !owner_req) begin
                    state_nxt = IDLE;
                    ptr_nxt   = idx + 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt   = IDLE;
                    ptr_nxt     = idx + 1'b1;
                    timeout_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign granted     = (state == GRANT);
    assign bus.busy    = granted;
    assign bus.gnt_idx = idx;
    assign bus.timeout = timeout_r;

    grant_decode u_grant_decode (
        .idx    (idx),
        .en     (granted),
        .onehot (bus.gnt)
    );

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - randomized scoreboard bench for rr_arbiter4
module tb_rr_arbiter4;

    localparam int MAX_HOLD = 4;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       busy;
        logic       to;
    } exp_t;

    logic clk;
    logic rst_n;

    rr_arbiter4_if bus ();

    rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks;
    int   failures;
    exp_t exp_q[$];

    int m_owner;
    int m_last;
    int m_ptr;
    int m_held;
    bit m_to;
    int m_to_cnt;
    int dut_to_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_last  = 0;
        m_ptr   = 0;
        m_held  = 0;
        m_to    = 0;
    endfunction

    // Arbiter rules: scan from the pointer, count grant cycles, release on done,
    // withdrawal or after MAX_HOLD cycles of ownership.
    function automatic void model_step(input logic [3:0] r, input logic d);
        bit forced;
        if (m_owner < 0) begin
            m_to = 0;
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (r[i]) begin
                    m_owner = i;
                    m_last  = i;
                    m_held  = 1;
                    break;
                end
            end
        end else begin
            forced = 0;
            if (d || !r[m_owner] || m_held == MAX_HOLD) begin
                forced  = !d && r[m_owner];
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end else begin
                m_held++;
            end
            m_to = forced;
            if (forced) m_to_cnt++;
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.gnt  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e.idx  = 2'(m_last);
        e.busy = (m_owner >= 0);
        e.to   = m_to;
        return e;
    endfunction

    task automatic step(input logic [3:0] r, input logic d);
        @(negedge clk);
        bus.req  = r;
        bus.done = d;
        model_step(r, d);
        exp_q.push_back(model_out());
    endtask

    task automatic pulse_reset(input logic [3:0] r_during);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_idx", 32'(bus.gnt_idx), 32'h0);
        chk("rst_timeout", 32'(bus.timeout), 32'h0);
        bus.req  = r_during;
        bus.done = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt", 32'(bus.gnt), 32'(e.gnt));
                chk("gnt_idx", 32'(bus.gnt_idx), 32'(e.idx));
                chk("busy", 32'(bus.busy), 32'(e.busy));
                chk("timeout", 32'(bus.timeout), 32'(e.to));
                if (bus.timeout === 1'b1) dut_to_cnt++;
            end
        end
    end

    initial begin : stimulus
        checks     = 0;
        failures   = 0;
        m_to_cnt   = 0;
        dut_to_cnt = 0;
        rst_n      = 1'b0;
        bus.req    = 4'b0000;
        bus.done   = 1'b0;
        model_reset();
        #7;
        chk("init_gnt", 32'(bus.gnt), 32'h0);
        chk("init_busy", 32'(bus.busy), 32'h0);
        chk("init_idx", 32'(bus.gnt_idx), 32'h0);
        chk("init_timeout", 32'(bus.timeout), 32'h0);
        #16;
        rst_n = 1'b1;

        // Single requester 2, then release leaves the pointer at 3.
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b1);
        step(4'b0000, 1'b0);

        // Pointer wrap with sparse requests: 0 first, then 1.
        step(4'b0011, 1'b0);
        step(4'b0011, 1'b1);
        step(4'b0011, 1'b0);
        step(4'b0011, 1'b1);
        step(4'b0000, 1'b0);

        // Full contention from a fresh pointer: owners 0,1,2,3,0.
        pulse_reset(4'b0000);
        for (int i = 0; i < 10; i++) step(4'b1111, m_owner >= 0);
        step(4'b0000, 1'b0);

        // Hold limit with done never asserted.
        for (int i = 0; i < 14; i++) step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);

        // done coincides with the hold limit.
        for (int i = 0; i < 8; i++) step(4'b0001, (m_owner >= 0) && (m_held == MAX_HOLD));
        step(4'b0000, 1'b0);

        // Asynchronous reset while requester 1 owns the resource.
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_reset_gnt", 32'(bus.gnt), 32'(model_out().gnt));
        pulse_reset(4'b1111);
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b1);
        step(4'b0000, 1'b0);

        for (int i = 0; i < 400; i++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
        end

        @(posedge clk);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        chk("timeout_count", 32'(dut_to_cnt), 32'(m_to_cnt));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
